// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture master.
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 24;
   localparam int DEF_DIV_W = 8;

   // Channel carried by a slot, as seen on ws_o.
   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK generator: latched half-period divider producing sck_o and the
// single-cycle rise/fall event strobes that pace the receive sequencer.
module i2s_sck_gen
   import i2s_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             sck_o,
   output logic             rise,
   output logic             fall
);

   logic [DIV_W-1:0] div_l_q, div_l_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sck_q, sck_d;
   logic             wrap;

   // Events are flagged in the cycle before sck_o actually changes.
   assign wrap  = run && (div_cnt_q == div_l_q);
   assign rise  = wrap && !sck_q;
   assign fall  = wrap && sck_q;
   assign sck_o = sck_q;

   always_comb begin
      div_l_d   = div_l_q;
      div_cnt_d = div_cnt_q;
      sck_d     = sck_q;
      if (start) begin
         div_l_d   = div;
         div_cnt_d = '0;
         sck_d     = 1'b0;
      end else if (!run) begin
         div_cnt_d = '0;
         sck_d     = 1'b0;
      end else if (wrap) begin
         div_cnt_d = '0;
         sck_d     = ~sck_q;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_l_q   <= '0;
         div_cnt_q <= '0;
         sck_q     <= 1'b0;
      end else begin
         div_l_q   <= div_l_d;
         div_cnt_q <= div_cnt_d;
         sck_q     <= sck_d;
      end
   end

endmodule

// File: rtl/i2s_master_ctrl.sv
// I2S receive master: drives SCK/WS, deserialises SD into stereo pairs and
// presents them on valid/ready with sticky overrun reporting.
module i2s_master_ctrl
   import i2s_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             sck_o,
   output logic             ws_o,
   input  logic             sd_i,
   output logic [WIDTH-1:0] left_data,
   output logic [WIDTH-1:0] right_data,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             overrun,
   input  logic             overrun_clr,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               ws_q, ws_d;
   // The oldest bit is never needed again, so only WIDTH-1 bits are kept.
   logic [WIDTH-2:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   left_hold_q, left_hold_d;
   logic [WIDTH-1:0]   left_data_q, left_data_d;
   logic [WIDTH-1:0]   right_data_q, right_data_d;
   logic               valid_q, valid_d;
   logic               overrun_q, overrun_d;
   logic               start, run, rise, fall, pair_done, slot_ch;
   logic [WIDTH-1:0]   word;

   assign start   = (state_q == ST_IDLE) && enable;
   assign run     = (state_q != ST_IDLE);
   assign word    = {shift_q, sd_i};
   assign slot_ch = ~ws_q;

   i2s_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .run     (run),
      .div     (div),
      .sck_o   (sck_o),
      .rise    (rise),
      .fall    (fall)
   );

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      ws_d         = ws_q;
      shift_d      = shift_q;
      left_hold_d  = left_hold_q;
      left_data_d  = left_data_q;
      right_data_d = right_data_q;
      valid_d      = valid_q;
      overrun_d    = overrun_q;
      pair_done    = 1'b0;

      case (state_q)
         ST_IDLE: if (enable) begin
            state_d   = ST_RUN;
            bit_cnt_d = CNT_W'(1);
            ws_d      = CH_LEFT;
         end
         ST_RUN: if (!enable) state_d = ST_DRAIN;
         // bit_cnt==0 with ws low only occurs right after a right word lands.
         ST_DRAIN: if (fall && (bit_cnt_q == '0) && (ws_q == CH_LEFT)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (rise) begin
         shift_d = word[WIDTH-2:0];
         if (bit_cnt_q == '0) begin
            if (slot_ch == CH_LEFT) left_hold_d = word;
            else if (slot_ch == CH_RIGHT) pair_done = 1'b1;
         end
      end

      if (fall) begin
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            ws_d      = ~ws_q;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end

      if (valid_q && sample_ready) valid_d = 1'b0;
      if (overrun_clr) overrun_d = 1'b0;
      // A pair landing while the previous one is still unconsumed is dropped.
      if (pair_done) begin
         if (!valid_q || sample_ready) begin
            left_data_d  = left_hold_q;
            right_data_d = word;
            valid_d      = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         ws_q         <= 1'b0;
         shift_q      <= '0;
         left_hold_q  <= '0;
         left_data_q  <= '0;
         right_data_q <= '0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         ws_q         <= ws_d;
         shift_q      <= shift_d;
         left_hold_q  <= left_hold_d;
         left_data_q  <= left_data_d;
         right_data_q <= right_data_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign ws_o         = ws_q;
   assign left_data    = left_data_q;
   assign right_data   = right_data_q;
   assign sample_valid = valid_q;
   assign overrun      = overrun_q;
   assign busy         = run;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Bench for i2s_master_ctrl: an I2S transmitter model feeds SD, expected
// stereo pairs are queued at stimulus time and popped on each handshake.
module tb_i2s_master_ctrl;

   localparam int WIDTH = 8;
   localparam int DIV_W = 8;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             enable = 1'b0;
   logic [DIV_W-1:0] div = 8'd1;
   logic             sample_ready = 1'b0;
   logic             overrun_clr = 1'b0;
   wire              sd_i;
   wire              sck_o, ws_o, sample_valid, overrun, busy;
   wire  [WIDTH-1:0] left_data, right_data;

   int total = 0;
   int bad = 0;

   logic [15:0] frames [0:15];
   logic [3:0]  tx_base = 4'd0;
   logic [3:0]  tx_fr = 4'd0;
   logic [3:0]  tx_bit = 4'd0;
   logic        sck_prev = 1'b0;
   logic [15:0] exp_q[$];

   i2s_master_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .div          (div),
      .sck_o        (sck_o),
      .ws_o         (ws_o),
      .sd_i         (sd_i),
      .left_data    (left_data),
      .right_data   (right_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Transmitter: continuous MSB-first L/R stream, advancing one bit after
   // every SCK rise and restarting at frame tx_base whenever the bus is idle.
   always @(negedge clk) begin
      if (!busy) begin
         tx_bit <= 4'd0;
         tx_fr  <= tx_base;
      end else if (sck_o && !sck_prev) begin
         if (tx_bit == 4'd15) begin
            tx_bit <= 4'd0;
            tx_fr  <= tx_fr + 4'd1;
         end else begin
            tx_bit <= tx_bit + 4'd1;
         end
      end
      sck_prev <= sck_o;
   end
   assign sd_i = frames[tx_fr][4'd15 - tx_bit];

   task automatic test_reset();
      logic seen;
      reset_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         enable       = 1'($urandom);
         sample_ready = 1'($urandom);
         overrun_clr  = 1'($urandom);
         div          = DIV_W'($urandom);
         @(negedge clk);
         total++;
         if ({sck_o, ws_o, sample_valid, overrun, busy, left_data, right_data} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs cycle %0d: got sck=%b ws=%b v=%b ovr=%b busy=%b l=%h r=%h, want all 0",
                     i, sck_o, ws_o, sample_valid, overrun, busy, left_data, right_data);
         end
      end
      enable = 1'b0; sample_ready = 1'b0; overrun_clr = 1'b0; div = 8'd1;
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sck_o || busy) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_release: sck/busy went high, want both 0");
      end
   endtask

   task automatic test_single_frame();
      int entry, first_rise, ws_t0, ws_t1, got, c;
      logic ws_prev;
      logic [15:0] exp;
      entry = -1; first_rise = -1; ws_t0 = -1; ws_t1 = -1; got = 0; c = 0;
      ws_prev = 1'b0;
      frames[0] = {8'hA5, 8'h3C};
      tx_base = 4'd0;
      exp_q.push_back(16'hA53C);
      sample_ready = 1'b1;
      enable = 1'b1;
      while (c < 300 && !(got > 0 && !busy)) begin
         @(negedge clk);
         if (busy && entry < 0) entry = c;
         if (entry >= 0 && sck_o && first_rise < 0) first_rise = c;
         if (ws_o !== ws_prev) begin
            if (ws_t0 < 0) ws_t0 = c;
            else if (ws_t1 < 0) ws_t1 = c;
         end
         ws_prev = ws_o;
         if (sample_valid && sample_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL single_unexpected: got %h, want no pair", {left_data, right_data});
            end else begin
               exp = exp_q.pop_front();
               if ({left_data, right_data} !== exp) begin
                  bad++;
                  $display("FAIL single_pair: got %h, want %h", {left_data, right_data}, exp);
               end
            end
            got++;
            enable = 1'b0;
         end
         c++;
      end
      total++;
      if (got != 1) begin
         bad++;
         $display("FAIL single_count: got %0d pairs, want 1", got);
      end
      total++;
      if (first_rise - entry != 2) begin
         bad++;
         $display("FAIL single_first_rise: got %0d clk after entry, want 2", first_rise - entry);
      end
      total++;
      if (ws_t1 - ws_t0 != 32) begin
         bad++;
         $display("FAIL single_ws_period: got %0d clk between toggles, want 32", ws_t1 - ws_t0);
      end
      total++;
      if ({busy, sck_o, ws_o} !== 3'b000) begin
         bad++;
         $display("FAIL single_stop: got busy/sck/ws=%b, want 000", {busy, sck_o, ws_o});
      end
   endtask

   task automatic test_backpressure();
      int c, held_err;
      logic seen_ovr;
      logic [15:0] exp;
      c = 0; held_err = 0; seen_ovr = 1'b0;
      frames[1] = {8'h11, 8'h22};
      frames[2] = {8'h33, 8'h44};
      frames[3] = {8'h55, 8'h66};
      tx_base = 4'd1;
      sample_ready = 1'b0;
      exp_q.push_back(16'h1122);
      enable = 1'b1;
      while (c < 400 && !(seen_ovr && !busy)) begin
         @(negedge clk);
         if (sample_valid && {left_data, right_data} !== 16'h1122) held_err++;
         if (overrun && !seen_ovr) begin
            seen_ovr = 1'b1;
            enable = 1'b0;
         end
         c++;
      end
      total++;
      if (seen_ovr !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_overrun: got overrun_seen=%b busy=%b, want 1 0", seen_ovr, busy);
      end
      total++;
      if (held_err != 0 || sample_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_hold: got %0d changes valid=%b data=%h, want 0 1 1122",
                  held_err, sample_valid, {left_data, right_data});
      end
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      total++;
      if (overrun !== 1'b0 || sample_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_clear: got overrun=%b valid=%b, want 0 1", overrun, sample_valid);
      end
      sample_ready = 1'b1;
      #1;
      total++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      if ({left_data, right_data} !== exp) begin
         bad++;
         $display("FAIL bp_consume: got %h, want %h", {left_data, right_data}, exp);
      end
      @(negedge clk);
      sample_ready = 1'b0;
      total++;
      if (sample_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_valid_drop: got valid=%b, want 0", sample_valid);
      end
   endtask

   task automatic test_simultaneous();
      int c;
      logic [15:0] exp;
      c = 0;
      frames[4] = {8'h5A, 8'hA5};
      frames[5] = {8'hC3, 8'h3C};
      tx_base = 4'd4;
      sample_ready = 1'b0;
      exp_q.push_back(16'h5AA5);
      exp_q.push_back(16'hC33C);
      enable = 1'b1;
      while (c < 200 && !sample_valid) begin
         @(negedge clk);
         c++;
      end
      // Second pair completes one frame (64 clk) after the first, minus one.
      repeat (63) @(negedge clk);
      sample_ready = 1'b1;
      total++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      if (sample_valid !== 1'b1 || {left_data, right_data} !== exp) begin
         bad++;
         $display("FAIL simul_first: got v=%b %h, want 1 %h", sample_valid, {left_data, right_data}, exp);
      end
      @(negedge clk);
      enable = 1'b0;
      total++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      if (sample_valid !== 1'b1 || overrun !== 1'b0 || {left_data, right_data} !== exp) begin
         bad++;
         $display("FAIL simul_second: got v=%b ovr=%b %h, want 1 0 %h",
                  sample_valid, overrun, {left_data, right_data}, exp);
      end
      @(negedge clk);
      total++;
      if (sample_valid !== 1'b0) begin
         bad++;
         $display("FAIL simul_drop: got valid=%b, want 0", sample_valid);
      end
      c = 0;
      while (c < 200 && busy) begin
         @(negedge clk);
         c++;
      end
      sample_ready = 1'b0;
   endtask

   task automatic test_stop_and_div();
      int c, got, entry, r0, r1;
      logic sprev;
      logic [15:0] exp;
      c = 0; got = 0;
      frames[6] = {8'h81, 8'h7E};
      tx_base = 4'd6;
      sample_ready = 1'b1;
      exp_q.push_back(16'h817E);
      enable = 1'b1;
      repeat (12) @(negedge clk);
      total++;
      if (busy !== 1'b1 || ws_o !== 1'b0) begin
         bad++;
         $display("FAIL stop_in_left: got busy=%b ws=%b, want 1 0", busy, ws_o);
      end
      enable = 1'b0;
      while (c < 300 && !(got > 0 && !busy)) begin
         @(negedge clk);
         if (sample_valid && sample_ready) begin
            total++;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            if ({left_data, right_data} !== exp) begin
               bad++;
               $display("FAIL stop_pair: got %h, want %h", {left_data, right_data}, exp);
            end
            got++;
         end
         c++;
      end
      total++;
      if (got != 1 || {busy, sck_o, ws_o} !== 3'b000) begin
         bad++;
         $display("FAIL stop_idle: got pairs=%0d busy/sck/ws=%b, want 1 000", got, {busy, sck_o, ws_o});
      end

      div = 8'd3;
      frames[7] = {8'hF0, 8'h0F};
      tx_base = 4'd7;
      exp_q.push_back(16'hF00F);
      c = 0; got = 0; entry = -1; r0 = -1; r1 = -1; sprev = 1'b0;
      enable = 1'b1;
      while (c < 600 && !(got > 0 && !busy)) begin
         @(negedge clk);
         if (busy && entry < 0) begin
            entry = c;
            div = 8'd1;
         end
         if (sck_o && !sprev) begin
            if (r0 < 0) r0 = c;
            else if (r1 < 0) r1 = c;
         end
         sprev = sck_o;
         if (sample_valid && sample_ready) begin
            total++;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            if ({left_data, right_data} !== exp) begin
               bad++;
               $display("FAIL div3_pair: got %h, want %h", {left_data, right_data}, exp);
            end
            got++;
            enable = 1'b0;
         end
         c++;
      end
      total++;
      if (r1 - r0 != 8 || r0 - entry != 4) begin
         bad++;
         $display("FAIL div3_period: got period=%0d first=%0d, want 8 4", r1 - r0, r0 - entry);
      end
      total++;
      if (got != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL div3_done: got pairs=%0d busy=%b, want 1 0", got, busy);
      end
      div = 8'd1;
   endtask

   task automatic test_async_reset();
      int c, got;
      logic [15:0] exp;
      c = 0; got = 0;
      frames[8] = {8'hDE, 8'hAD};
      frames[9] = {8'h69, 8'h96};
      tx_base = 4'd8;
      sample_ready = 1'b1;
      enable = 1'b1;
      repeat (40) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({sck_o, ws_o, sample_valid, overrun, busy, left_data, right_data} !== 21'd0) begin
         bad++;
         $display("FAIL async_reset: got sck=%b ws=%b v=%b ovr=%b busy=%b l=%h r=%h, want all 0",
                  sck_o, ws_o, sample_valid, overrun, busy, left_data, right_data);
      end
      tx_base = 4'd9;
      exp_q.push_back(16'h6996);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      while (c < 300 && !(got > 0 && !busy)) begin
         @(negedge clk);
         if (sample_valid && sample_ready) begin
            total++;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            if ({left_data, right_data} !== exp) begin
               bad++;
               $display("FAIL restart_pair: got %h, want %h", {left_data, right_data}, exp);
            end
            got++;
            enable = 1'b0;
         end
         c++;
      end
      total++;
      if (got != 1) begin
         bad++;
         $display("FAIL restart_count: got %0d pairs, want 1", got);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) frames[i] = 16'h0000;
      test_reset();
      test_single_frame();
      test_backpressure();
      test_simultaneous();
      test_stop_and_div();
      test_async_reset();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_empty: got %0d pending pairs, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
